// File: rtl/pd_tx_symbol_serializer.sv
// USB-PD transmit serializer: preamble, ordered set, 4b5b payload and EOP, one bit per BMC bit_rdy.
// A one-byte prefetch register decouples the byte stream from the bit-level handshake.
module pd_tx_symbol_serializer #(
   parameter int unsigned PREAMBLE_BITS = 64
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] sop_type,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   input  logic       byte_last,
   output logic       byte_ready,
   input  logic       bit_rdy,
   output logic       bit_q,
   output logic       tx_en,
   output logic       busy,
   output logic       underrun
);

   localparam int unsigned      CNT_W          = $clog2(PREAMBLE_BITS + 1);
   localparam logic [CNT_W-1:0] PRE_LAST       = CNT_W'(PREAMBLE_BITS - 1);
   localparam logic [2:0]       SYM_LAST       = 3'd4;
   localparam logic [1:0]       SOP_HARD_RESET = 2'd3;

   localparam logic [4:0] K_S1  = 5'b11000;
   localparam logic [4:0] K_S2  = 5'b10001;
   localparam logic [4:0] K_S3  = 5'b00110;
   localparam logic [4:0] K_R1  = 5'b00111;
   localparam logic [4:0] K_R2  = 5'b11001;
   localparam logic [4:0] K_EOP = 5'b01101;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      ORDSET   = 3'd2,
      DATA     = 3'd3,
      EOP      = 3'd4,
      FLUSH    = 3'd5
   } state_t;

   // 4b5b data symbol for one nibble
   function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
      logic [4:0] s;
      case (nib)
         4'h0:    s = 5'b11110;
         4'h1:    s = 5'b01001;
         4'h2:    s = 5'b10100;
         4'h3:    s = 5'b10101;
         4'h4:    s = 5'b01010;
         4'h5:    s = 5'b01011;
         4'h6:    s = 5'b01110;
         4'h7:    s = 5'b01111;
         4'h8:    s = 5'b10010;
         4'h9:    s = 5'b10011;
         4'hA:    s = 5'b10110;
         4'hB:    s = 5'b10111;
         4'hC:    s = 5'b11010;
         4'hD:    s = 5'b11011;
         4'hE:    s = 5'b11100;
         default: s = 5'b11101;
      endcase
      return s;
   endfunction

   // K-code at position idx of the ordered set selected by sop
   function automatic logic [4:0] kcode(input logic [1:0] sop, input logic [1:0] idx);
      logic [4:0] k;
      case (sop)
         2'd0:    k = (idx == 2'd3) ? K_S2 : K_S1;
         2'd1:    k = idx[1] ? K_S3 : K_S1;
         2'd2:    k = idx[0] ? K_S3 : K_S1;
         default: k = (idx == 2'd3) ? K_R2 : K_R1;
      endcase
      return k;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [1:0]       sym_idx_q, sym_idx_d;
   logic [4:0]       sym_q, sym_d;
   logic [1:0]       sop_q, sop_d;
   logic [7:0]       cur_byte_q, cur_byte_d;
   logic             cur_last_q, cur_last_d;
   logic             nib_hi_q, nib_hi_d;
   logic [7:0]       pf_data_q, pf_data_d;
   logic             pf_last_q, pf_last_d;
   logic             pf_valid_q, pf_valid_d;
   logic             last_seen_q, last_seen_d;
   logic             out_bit_q, out_bit_d;
   logic             tx_en_q, tx_en_d;
   logic             busy_q, busy_d;
   logic             byte_ready_q, byte_ready_d;
   logic             underrun_q, underrun_d;

   logic             xfer;
   logic             avail;
   logic [7:0]       nxt_byte;
   logic             nxt_last;
   logic             need_byte;
   logic             load_sym;
   logic [4:0]       new_sym;

   assign bit_q      = out_bit_q;
   assign tx_en      = tx_en_q;
   assign busy       = busy_q;
   assign byte_ready = byte_ready_q;
   assign underrun   = underrun_q;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         sym_idx_q    <= '0;
         sym_q        <= '0;
         sop_q        <= '0;
         cur_byte_q   <= '0;
         cur_last_q   <= 1'b0;
         nib_hi_q     <= 1'b0;
         pf_data_q    <= '0;
         pf_last_q    <= 1'b0;
         pf_valid_q   <= 1'b0;
         last_seen_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         tx_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         byte_ready_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         sym_idx_q    <= sym_idx_d;
         sym_q        <= sym_d;
         sop_q        <= sop_d;
         cur_byte_q   <= cur_byte_d;
         cur_last_q   <= cur_last_d;
         nib_hi_q     <= nib_hi_d;
         pf_data_q    <= pf_data_d;
         pf_last_q    <= pf_last_d;
         pf_valid_q   <= pf_valid_d;
         last_seen_q  <= last_seen_d;
         out_bit_q    <= out_bit_d;
         tx_en_q      <= tx_en_d;
         busy_q       <= busy_d;
         byte_ready_q <= byte_ready_d;
         underrun_q   <= underrun_d;
      end
   end

   // Next-state, bit sequencing and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      sym_idx_d    = sym_idx_q;
      sym_d        = sym_q;
      sop_d        = sop_q;
      cur_byte_d   = cur_byte_q;
      cur_last_d   = cur_last_q;
      nib_hi_d     = nib_hi_q;
      pf_data_d    = pf_data_q;
      pf_last_d    = pf_last_q;
      pf_valid_d   = pf_valid_q;
      last_seen_d  = last_seen_q;
      out_bit_d    = out_bit_q;
      underrun_d   = 1'b0;
      need_byte    = 1'b0;
      load_sym     = 1'b0;
      new_sym      = sym_q;

      // A byte arriving on the very cycle it is needed is used directly.
      xfer     = byte_valid && byte_ready_q;
      avail    = pf_valid_q || xfer;
      nxt_byte = pf_valid_q ? pf_data_q : byte_data;
      nxt_last = pf_valid_q ? pf_last_q : byte_last;

      if (xfer) begin
         pf_valid_d = 1'b1;
         pf_data_d  = byte_data;
         pf_last_d  = byte_last;
         if (byte_last) begin
            last_seen_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = PREAMBLE;
               sop_d       = sop_type;
               cnt_d       = '0;
               bit_idx_d   = '0;
               sym_idx_d   = '0;
               nib_hi_d    = 1'b0;
               pf_valid_d  = 1'b0;
               last_seen_d = 1'b0;
               out_bit_d   = 1'b0;
            end
         end
         PREAMBLE: begin
            if (bit_rdy) begin
               if (cnt_q == PRE_LAST) begin
                  state_d   = ORDSET;
                  sym_idx_d = 2'd0;
                  new_sym   = kcode(sop_q, 2'd0);
                  load_sym  = 1'b1;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  out_bit_d = ~out_bit_q;
               end
            end
         end
         ORDSET, DATA, EOP: begin
            if (bit_rdy) begin
               if (bit_idx_q != SYM_LAST) begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  out_bit_d = sym_q[bit_idx_d];
                  // The frame's final bit is held in FLUSH until the encoder takes it.
                  if ((bit_idx_q == 3'd3) &&
                      ((state_q == EOP) ||
                       ((state_q == ORDSET) && (sop_q == SOP_HARD_RESET) && (sym_idx_q == 2'd3)))) begin
                     state_d = FLUSH;
                  end
               end else if (state_q == ORDSET) begin
                  if (sym_idx_q != 2'd3) begin
                     sym_idx_d = sym_idx_q + 2'd1;
                     new_sym   = kcode(sop_q, sym_idx_d);
                     load_sym  = 1'b1;
                  end else begin
                     need_byte = 1'b1;
                  end
               end else if ((state_q == DATA) && !nib_hi_q) begin
                  nib_hi_d = 1'b1;
                  new_sym  = enc_4b5b(cur_byte_q[7:4]);
                  load_sym = 1'b1;
               end else if ((state_q == DATA) && !cur_last_q) begin
                  need_byte = 1'b1;
               end else if (state_q == DATA) begin
                  state_d  = EOP;
                  new_sym  = K_EOP;
                  load_sym = 1'b1;
               end else begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (bit_rdy) begin
               state_d   = IDLE;
               out_bit_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Payload byte needed: consume prefetch or starve into EOP.
      if (need_byte) begin
         if (avail) begin
            state_d    = DATA;
            cur_byte_d = nxt_byte;
            cur_last_d = nxt_last;
            pf_valid_d = 1'b0;
            nib_hi_d   = 1'b0;
            new_sym    = enc_4b5b(nxt_byte[3:0]);
            load_sym   = 1'b1;
         end else begin
            state_d    = EOP;
            underrun_d = 1'b1;
            new_sym    = K_EOP;
            load_sym   = 1'b1;
         end
      end

      if (load_sym) begin
         sym_d     = new_sym;
         bit_idx_d = 3'd0;
         out_bit_d = new_sym[0];
      end

      busy_d       = (state_d != IDLE);
      tx_en_d      = (state_d != IDLE);
      byte_ready_d = ((state_d == ORDSET) || (state_d == DATA)) && !pf_valid_d &&
                     !last_seen_d && (sop_d != SOP_HARD_RESET);
   end

endmodule
